// File: rtl/vga_pkg.sv
// Shared pattern codes, default 640x480 timing and the frame-lock state type
// for the VGA test-pattern path.
package vga_pkg;

  localparam logic [2:0] PAT_BLACK = 3'd0;
  localparam logic [2:0] PAT_RED   = 3'd1;
  localparam logic [2:0] PAT_GREEN = 3'd2;
  localparam logic [2:0] PAT_BLUE  = 3'd3;
  localparam logic [2:0] PAT_WHITE = 3'd4;
  localparam logic [2:0] PAT_BARS  = 3'd5;
  localparam logic [2:0] PAT_CHECK = 3'd6;
  localparam logic [2:0] PAT_BOX   = 3'd7;

  localparam int DEF_TOTAL_COLS  = 800;
  localparam int DEF_TOTAL_ROWS  = 525;
  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } vga_state_e;

  // Channel enables {red, green, blue} for the flat-colour codes; every other code is black here.
  function automatic logic [2:0] solid_rgb(input logic [2:0] pat);
    case (pat)
      PAT_RED:   return 3'b100;
      PAT_GREEN: return 3'b010;
      PAT_BLUE:  return 3'b001;
      PAT_WHITE: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Regenerates column/row position from the incoming V sync edge and reports
// whether the stream has locked to a frame.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS = DEF_TOTAL_ROWS,
  parameter int COL_W      = $clog2(TOTAL_COLS),
  parameter int ROW_W      = $clog2(TOTAL_ROWS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_V_Sync,
  output logic [COL_W-1:0] col_p1,
  output logic [ROW_W-1:0] row_p1,
  output logic             frame_start_p1,
  output logic             vld_p1
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROWS - 1);

  vga_state_e state;
  logic       v_prev;
  logic       v_rise;

  assign v_rise = i_V_Sync & ~v_prev;

  // v_prev comes out of reset high so that releasing reset while V is already
  // high (mid-frame) is not mistaken for a frame start.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= WAIT_FRAME;
      v_prev <= 1'b1;
      col_p1 <= '0;
      row_p1 <= '0;
    end else begin
      v_prev <= i_V_Sync;
      if (v_rise) begin
        col_p1 <= '0;
        row_p1 <= '0;
      end else if (col_p1 == COL_LAST) begin
        col_p1 <= '0;
        row_p1 <= (row_p1 == ROW_LAST) ? '0 : row_p1 + 1'b1;
      end else begin
        col_p1 <= col_p1 + 1'b1;
      end
      case (state)
        WAIT_FRAME: if (v_rise) state <= RUN;
        RUN:        state <= RUN;
      endcase
    end
  end

  assign vld_p1         = (state == RUN);
  assign frame_start_p1 = vld_p1 && (col_p1 == '0) && (row_p1 == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern source: eight selectable patterns generated from recovered
// pixel position, with syncs delayed to stay aligned with colour.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W     = 3,
  parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int BOX_SIZE    = 32,
  parameter int CHECK_LOG2  = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               i_H_Sync,
  input  logic               i_V_Sync,
  input  logic [2:0]         i_Pattern,
  output logic               o_H_Sync,
  output logic               o_V_Sync,
  output logic [COLOR_W-1:0] o_Red,
  output logic [COLOR_W-1:0] o_Green,
  output logic [COLOR_W-1:0] o_Blue
);

  localparam int COL_W = $clog2(TOTAL_COLS);
  localparam int ROW_W = $clog2(TOTAL_ROWS);
  localparam int BAR_W = ACTIVE_COLS / 8;

  localparam logic [COL_W-1:0] ACT_X = COL_W'(ACTIVE_COLS);
  localparam logic [ROW_W-1:0] ACT_Y = ROW_W'(ACTIVE_ROWS);
  localparam logic [COL_W-1:0] X_LIM = COL_W'(ACTIVE_COLS - BOX_SIZE);
  localparam logic [ROW_W-1:0] Y_LIM = ROW_W'(ACTIVE_ROWS - BOX_SIZE);
  localparam logic [COL_W-1:0] BOX_X = COL_W'(BOX_SIZE);
  localparam logic [ROW_W-1:0] BOX_Y = ROW_W'(BOX_SIZE);

  logic [COL_W-1:0] col_p1;
  logic [ROW_W-1:0] row_p1;
  logic             frame_start_p1;
  logic             vld_p1;
  logic             h_p1;
  logic             v_p1;

  logic [2:0]       pat_q;
  logic [COL_W-1:0] bx_q;
  logic [ROW_W-1:0] by_q;
  logic             vx_neg_q;
  logic             vy_neg_q;

  logic [COL_W-1:0] bx_nxt;
  logic [ROW_W-1:0] by_nxt;
  logic             vx_neg_nxt;
  logic             vy_neg_nxt;

  logic [2:0]       pat_eff;
  logic [COL_W-1:0] bx_eff;
  logic [ROW_W-1:0] by_eff;

  logic             active_p1;
  logic             in_box_p1;
  logic             check_p1;
  logic [2:0]       bar_p1;
  logic [2:0]       rgb_p1;

  // Bar index by threshold compare, avoiding a divider for non-power-of-two bar widths.
  function automatic logic [2:0] bar_index(input logic [COL_W-1:0] col);
    logic [2:0] idx;
    idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (col >= COL_W'(k * BAR_W)) idx = 3'(k);
    end
    return idx;
  endfunction

  vga_sync_counter #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W)
  ) u_sync_counter (
    .CLK            (CLK),
    .RST            (RST),
    .i_V_Sync       (i_V_Sync),
    .col_p1         (col_p1),
    .row_p1         (row_p1),
    .frame_start_p1 (frame_start_p1),
    .vld_p1         (vld_p1)
  );

  // ---- stage 1: sync capture (counters live in u_sync_counter) ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_p1 <= 1'b0;
      v_p1 <= 1'b0;
    end else begin
      h_p1 <= i_H_Sync;
      v_p1 <= i_V_Sync;
    end
  end

  always_comb begin
    bx_nxt     = bx_q;
    vx_neg_nxt = vx_neg_q;
    if (!vx_neg_q) begin
      if (bx_q == X_LIM) begin
        vx_neg_nxt = 1'b1;
        bx_nxt     = bx_q - 1'b1;
      end else begin
        bx_nxt     = bx_q + 1'b1;
      end
    end else begin
      if (bx_q == '0) begin
        vx_neg_nxt = 1'b0;
        bx_nxt     = bx_q + 1'b1;
      end else begin
        bx_nxt     = bx_q - 1'b1;
      end
    end

    by_nxt     = by_q;
    vy_neg_nxt = vy_neg_q;
    if (!vy_neg_q) begin
      if (by_q == Y_LIM) begin
        vy_neg_nxt = 1'b1;
        by_nxt     = by_q - 1'b1;
      end else begin
        by_nxt     = by_q + 1'b1;
      end
    end else begin
      if (by_q == '0) begin
        vy_neg_nxt = 1'b0;
        by_nxt     = by_q + 1'b1;
      end else begin
        by_nxt     = by_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pat_q    <= PAT_BLACK;
      bx_q     <= '0;
      by_q     <= '0;
      vx_neg_q <= 1'b0;
      vy_neg_q <= 1'b0;
    end else if (frame_start_p1) begin
      pat_q    <= i_Pattern;
      bx_q     <= bx_nxt;
      by_q     <= by_nxt;
      vx_neg_q <= vx_neg_nxt;
      vy_neg_q <= vy_neg_nxt;
    end
  end

  // Pixel (0,0) is coloured in the frame-start cycle itself, so it sees the
  // values being latched rather than last frame's.
  assign pat_eff = frame_start_p1 ? i_Pattern : pat_q;
  assign bx_eff  = frame_start_p1 ? bx_nxt    : bx_q;
  assign by_eff  = frame_start_p1 ? by_nxt    : by_q;

  assign active_p1 = (col_p1 < ACT_X) && (row_p1 < ACT_Y);
  assign in_box_p1 = (col_p1 >= bx_eff) && (col_p1 < bx_eff + BOX_X) &&
                     (row_p1 >= by_eff) && (row_p1 < by_eff + BOX_Y);
  assign check_p1  = col_p1[CHECK_LOG2] ^ row_p1[CHECK_LOG2];
  assign bar_p1    = bar_index(col_p1);

  always_comb begin
    rgb_p1 = 3'b000;
    if (vld_p1 && active_p1) begin
      case (pat_eff)
        PAT_BARS:  rgb_p1 = bar_p1;
        PAT_CHECK: rgb_p1 = {3{check_p1}};
        PAT_BOX:   rgb_p1 = {3{in_box_p1}};
        default:   rgb_p1 = solid_rgb(pat_eff);
      endcase
    end
  end

  // ---- stage 2: colour and delayed syncs leave together ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_H_Sync <= 1'b0;
      o_V_Sync <= 1'b0;
      o_Red    <= '0;
      o_Green  <= '0;
      o_Blue   <= '0;
    end else begin
      o_H_Sync <= h_p1;
      o_V_Sync <= v_p1;
      o_Red    <= {COLOR_W{rgb_p1[2]}};
      o_Green  <= {COLOR_W{rgb_p1[1]}};
      o_Blue   <= {COLOR_W{rgb_p1[0]}};
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen at a reduced raster so that box
// bounces, resyncs and mid-frame resets all fit in a short run.
module tb_vga_pattern_gen;

  localparam int CW  = 3;
  localparam int TC  = 36;
  localparam int TR  = 18;
  localparam int AC  = 32;
  localparam int AR  = 16;
  localparam int BOX = 4;
  localparam int CL  = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          h   = 1'b0;
  logic          v   = 1'b0;
  logic [2:0]    pat = 3'd0;
  logic          oh;
  logic          ov;
  logic [CW-1:0] red;
  logic [CW-1:0] grn;
  logic [CW-1:0] blu;

  vga_pattern_gen #(
    .COLOR_W     (CW),
    .TOTAL_COLS  (TC),
    .TOTAL_ROWS  (TR),
    .ACTIVE_COLS (AC),
    .ACTIVE_ROWS (AR),
    .BOX_SIZE    (BOX),
    .CHECK_LOG2  (CL)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .i_H_Sync  (h),
    .i_V_Sync  (v),
    .i_Pattern (pat),
    .o_H_Sync  (oh),
    .o_V_Sync  (ov),
    .o_Red     (red),
    .o_Green   (grn),
    .o_Blue    (blu)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } obs_t;

  obs_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Sync-source position and the reference view of the generator.
  int gc, gr;
  bit rst_req;
  bit m_run;
  bit m_prev_v;
  int m_pat;
  int bx, by, vx, vy;

  function automatic void model_reset();
    m_run    = 1'b0;
    m_prev_v = 1'b1;
    m_pat    = 0;
    bx = 0; by = 0; vx = 1; vy = 1;
  endfunction

  function automatic void move_box();
    if (vx > 0 && bx == AC - BOX) begin vx = -1; bx = bx - 1; end
    else if (vx < 0 && bx == 0)   begin vx = 1;  bx = bx + 1; end
    else bx = bx + vx;
    if (vy > 0 && by == AR - BOX) begin vy = -1; by = by - 1; end
    else if (vy < 0 && by == 0)   begin vy = 1;  by = by + 1; end
    else by = by + vy;
  endfunction

  function automatic obs_t ref_pixel(input int c, input int r, input bit hs, input bit vs);
    obs_t o;
    bit on_r, on_g, on_b;
    int bar;
    on_r = 0; on_g = 0; on_b = 0;
    if (m_run && c < AC && r < AR) begin
      case (m_pat)
        1: on_r = 1;
        2: on_g = 1;
        3: on_b = 1;
        4: begin on_r = 1; on_g = 1; on_b = 1; end
        5: begin
          bar  = c / (AC / 8);
          on_r = bar[2]; on_g = bar[1]; on_b = bar[0];
        end
        6: begin
          on_r = (((c >> CL) ^ (r >> CL)) & 1) == 1;
          on_g = on_r; on_b = on_r;
        end
        7: begin
          on_r = (c >= bx) && (c < bx + BOX) && (r >= by) && (r < by + BOX);
          on_g = on_r; on_b = on_r;
        end
        default: ;
      endcase
    end
    o.hs = hs;
    o.vs = vs;
    o.r  = {CW{on_r}};
    o.g  = {CW{on_g}};
    o.b  = {CW{on_b}};
    return o;
  endfunction

  task automatic drive_cycle(input bit force_v_low);
    obs_t e;
    @(posedge CLK);
    #1;
    RST = rst_req;
    h   = (gc < AC);
    v   = force_v_low ? 1'b0 : (gr < AR);
    if (RST) begin
      model_reset();
      e = '0;
    end else begin
      if (v && !m_prev_v) m_run = 1'b1;
      m_prev_v = v;
      if (m_run && gc == 0 && gr == 0) begin
        m_pat = int'(pat);
        move_box();
      end
      e = ref_pixel(gc, gr, h, v);
    end
    sb.push_back(e);
    if (gc == TC - 1) begin
      gc = 0;
      gr = (gr == TR - 1) ? 0 : gr + 1;
    end else begin
      gc = gc + 1;
    end
  endtask

  task automatic run_to(input int c, input int r);
    int n;
    n = 0;
    while (!(gc == c && gr == r) && n < TC * TR) begin
      drive_cycle(1'b0);
      n++;
    end
  endtask

  task automatic run_frames(input int nfr);
    repeat (nfr * TC * TR) drive_cycle(1'b0);
  endtask

  // Pattern requests are made mid-frame so they land at the following frame start.
  task automatic next_pattern(input int p, input int nfr);
    run_to(5, 10);
    pat = 3'(p);
    run_frames(nfr);
  endtask

  // Early V edge: the sync source drops V for one pixel, then restarts at (0,0).
  task automatic resync_at(input int c, input int r);
    run_to(c, r);
    drive_cycle(1'b1);
    gc = 0;
    gr = 0;
  endtask

  initial begin : monitor
    obs_t e;
    obs_t act;
    forever begin
      @(negedge CLK);
      act = '{hs: oh, vs: ov, r: red, g: grn, b: blu};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty @%0t got h=%0b v=%0b rgb=%0d,%0d,%0d", $time,
                 act.hs, act.vs, act.r, act.g, act.b);
      end else begin
        e = sb.pop_front();
        if (RST) e = '0;
        if (act !== e) begin
          bad++;
          $display("FAIL pixel @%0t got h=%0b v=%0b rgb=%0d,%0d,%0d want h=%0b v=%0b rgb=%0d,%0d,%0d",
                   $time, act.hs, act.vs, act.r, act.g, act.b, e.hs, e.vs, e.r, e.g, e.b);
        end
      end
    end
  end

  initial begin : watchdog
    #(2_000_000);
    $display("FAIL watchdog time limit reached total=%0d", total);
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    sb.push_back('0);
    sb.push_back('0);
    model_reset();
    gc = 0;
    gr = AR;
    rst_req = 1'b1;
    pat = 3'd1;
    repeat (4) drive_cycle(1'b0);
    rst_req = 1'b0;
    run_frames(2);

    next_pattern(5, 1);
    next_pattern(6, 1);
    next_pattern(2, 1);
    next_pattern(3, 1);

    next_pattern(7, 34);

    next_pattern(6, 1);
    resync_at(10, 8);
    run_frames(1);
    resync_at(TC - 1, 5);
    run_frames(1);
    resync_at(0, AR);
    run_frames(1);

    next_pattern(4, 1);
    run_to(10, 8);
    rst_req = 1'b1;
    repeat (5) drive_cycle(1'b0);
    rst_req = 1'b0;
    run_frames(2);

    repeat (10) begin
      run_to(int'($urandom_range(0, TC - 1)), int'($urandom_range(2, AR - 2)));
      pat = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0)
        resync_at(int'($urandom_range(0, TC - 1)), int'($urandom_range(1, TR - 1)));
    end
    run_frames(1);

    repeat (3) @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
